// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
//   SPI master engine (mode 0). It watches the SPI control register, and when
//   the send bit is set it runs one transaction of n_tx_end+1 bytes against the
//   byte data RAM. Each received byte overwrites the byte it replaced. At the
//   end it writes the control word back with send cleared and n_rx_end set.
//
// Configuration macro:
//   SPI_LSB_FIRST_EN  defined   -> bit 0 first on MOSI, rx assembled LSB first
//                     undefined -> MSB first in both directions (PMOD ALS)
//
// Ports:
//   clk_i        system clock (10 MHz)
//   rst_n_i      synchronous reset, active low
//   ctrl_i       current control register contents
//   ctrl_wr_o    1-cycle write strobe into the control register
//   ctrl_data_o  word written back with ctrl_wr_o
//   mem_addr_o   data RAM byte index
//   mem_rdata_i  data RAM read data (sync read, 1-cycle latency, [7:0] used)
//   mem_we_o     data RAM write enable (received byte)
//   mem_wdata_o  {24'h0, rx_byte}
//   sclk_o       SPI clock, idles low
//   cs_n_o       chip select, active low (only driven low when cs_ctrl is set)
//   mosi_o       master out
//   miso_i       master in
//   busy_o       high whenever the engine is not idle
// -----------------------------------------------------------------------------
module spi_master_ctrl #(
  parameter int HALF_PER = 5,
  parameter int AW       = 9
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [31:0]   ctrl_i,
  output logic          ctrl_wr_o,
  output logic [31:0]   ctrl_data_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic [31:0]   mem_rdata_i,
  output logic          mem_we_o,
  output logic [31:0]   mem_wdata_o,
  output logic          sclk_o,
  output logic          cs_n_o,
  output logic          mosi_o,
  input  logic          miso_i,
  output logic          busy_o
);

  localparam int DW = (HALF_PER > 2) ? $clog2(HALF_PER) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RD_WAIT = 3'd2,
    S_SHIFT   = 3'd3,
    S_STORE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t          state_q;
  logic [31:0]     shadow_q;
  logic [AW-1:0]   byte_cnt_q;
  logic [DW-1:0]   div_q;
  logic [3:0]      half_q;
  logic [7:0]      tx_q;
  logic [7:0]      rx_q;
  logic            sclk_q;
  logic            cs_n_q;
  logic            mosi_q;
  logic            ctrl_wr_q;
  logic [31:0]     ctrl_data_q;
  logic [AW-1:0]   mem_addr_q;
  logic            mem_we_q;
  logic [7:0]      mem_wdata_q;
  logic            busy_q;

  logic [7:0]      tx_byte_d;
  logic            tx_first_d;
  logic [7:0]      tx_shift_d;
  logic            mosi_next_d;
  logic [7:0]      rx_shift_d;
  logic            div_last_d;
  logic            last_byte_d;

  // Upper RAM data bits and the old n_rx_end field are intentionally ignored.
  logic            unused_s;
  assign unused_s = ^{mem_rdata_i[31:8], shadow_q[25:16]};

  // Byte to transmit: all_1s has priority over all_0s, otherwise RAM data.
  always_comb begin
    tx_byte_d = mem_rdata_i[7:0];
    if (shadow_q[2]) begin
      tx_byte_d = 8'hFF;
    end else if (shadow_q[3]) begin
      tx_byte_d = 8'h00;
    end else begin
      tx_byte_d = mem_rdata_i[7:0];
    end
  end

  // Bit-order dependent shift paths.
`ifdef SPI_LSB_FIRST_EN
  assign tx_first_d  = tx_byte_d[0];
  assign tx_shift_d  = {1'b0, tx_q[7:1]};
  assign mosi_next_d = tx_shift_d[0];
  assign rx_shift_d  = {miso_i, rx_q[7:1]};
`else
  assign tx_first_d  = tx_byte_d[7];
  assign tx_shift_d  = {tx_q[6:0], 1'b0};
  assign mosi_next_d = tx_shift_d[7];
  assign rx_shift_d  = {rx_q[6:0], miso_i};
`endif

  assign div_last_d  = (div_q == DW'(HALF_PER - 1));
  assign last_byte_d = (byte_cnt_q == shadow_q[4 +: AW]);

  // Transaction sequencer with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      shadow_q    <= 32'h0;
      byte_cnt_q  <= '0;
      div_q       <= '0;
      half_q      <= 4'd0;
      tx_q        <= 8'h00;
      rx_q        <= 8'h00;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      ctrl_wr_q   <= 1'b0;
      ctrl_data_q <= 32'h0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ctrl_i[0]) begin
            shadow_q   <= ctrl_i;
            byte_cnt_q <= '0;
            // Address is presented during LOAD so data is ready after RD_WAIT.
            mem_addr_q <= '0;
            cs_n_q     <= ~ctrl_i[1];
            busy_q     <= 1'b1;
            state_q    <= S_LOAD;
          end
        end
        S_LOAD: begin
          state_q <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          tx_q    <= tx_byte_d;
          mosi_q  <= tx_first_d;
          div_q   <= '0;
          half_q  <= 4'd0;
          sclk_q  <= 1'b0;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_last_d) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
            if (!sclk_q) begin
              // Rising edge: sample MISO.
              rx_q <= rx_shift_d;
            end else begin
              // Falling edge: present the next transmit bit.
              tx_q   <= tx_shift_d;
              mosi_q <= mosi_next_d;
            end
            if (half_q == 4'd15) begin
              mem_we_q    <= 1'b1;
              mem_wdata_q <= rx_q;
              state_q     <= S_STORE;
            end else begin
              half_q <= half_q + 4'd1;
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        S_STORE: begin
          mem_we_q <= 1'b0;
          if (last_byte_d) begin
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            ctrl_wr_q   <= 1'b1;
            ctrl_data_q <= {shadow_q[31:26], 10'(byte_cnt_q), shadow_q[15:1], 1'b0};
            state_q     <= S_DONE;
          end else begin
            byte_cnt_q <= byte_cnt_q + AW'(1);
            mem_addr_q <= byte_cnt_q + AW'(1);
            state_q    <= S_LOAD;
          end
        end
        S_DONE: begin
          // The register takes the writeback on this edge, so IDLE sees send=0.
          ctrl_wr_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          sclk_q    <= 1'b0;
          cs_n_q    <= 1'b1;
          mem_we_q  <= 1'b0;
          ctrl_wr_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl_wr_o   = ctrl_wr_q;
  assign ctrl_data_o = ctrl_data_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_wdata_o = {24'h0, mem_wdata_q};
  assign sclk_o      = sclk_q;
  assign cs_n_o      = cs_n_q;
  assign mosi_o      = mosi_q;
  assign busy_o      = busy_q;

endmodule
